// File: rtl/arbiter_wrr_lock.sv
// Weighted round-robin arbiter with registered one-hot grant, per-beat ack and packet lock.
// Each holder keeps the grant for weight[i] acked beats (0 counts as 1) unless its lock is set.
module arbiter_wrr_lock #(
   parameter int unsigned REQ_WIDTH = 8,
   parameter int unsigned WEIGHT_W  = 4,
   localparam int unsigned IDX_W    = $clog2(REQ_WIDTH)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [REQ_WIDTH-1:0]          req,
   input  logic [REQ_WIDTH*WEIGHT_W-1:0] weight,
   input  logic [REQ_WIDTH-1:0]          lock,
   input  logic                          ack,
   output logic [REQ_WIDTH-1:0]          gnt,
   output logic                          gnt_vld,
   output logic [IDX_W-1:0]              gnt_idx
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                state;
   logic [REQ_WIDTH-1:0]  mask;
   logic [WEIGHT_W-1:0]   credit;

   logic                  withdrew;
   logic [REQ_WIDTH-1:0]  cand;
   logic [REQ_WIDTH-1:0]  masked;
   logic [IDX_W-1:0]      m_idx;
   logic [IDX_W-1:0]      u_idx;
   logic [IDX_W-1:0]      pick_idx;
   logic [WEIGHT_W-1:0]   pick_weight;
   logic [WEIGHT_W-1:0]   pick_credit;
   logic [REQ_WIDTH-1:0]  pick_mask;
   logic [REQ_WIDTH-1:0]  pick_onehot;
   logic                  start;
   logic                  rearb;
   logic                  dec;
   logic                  load;
   logic                  drop;

   // Rotating-priority pick and event decode for the current cycle
   always_comb begin
      withdrew    = (state == BUSY) && !req[gnt_idx];
      cand        = withdrew ? (req & ~gnt) : req;
      masked      = cand & mask;
      m_idx       = '0;
      u_idx       = '0;
      for (int i = REQ_WIDTH - 1; i >= 0; i--) begin
         if (masked[i]) m_idx = IDX_W'(i);
         if (cand[i])   u_idx = IDX_W'(i);
      end
      pick_idx    = (|masked) ? m_idx : u_idx;
      pick_weight = weight[int'(pick_idx)*WEIGHT_W +: WEIGHT_W];
      pick_credit = (pick_weight == '0) ? WEIGHT_W'(1) : pick_weight;
      for (int i = 0; i < REQ_WIDTH; i++) begin
         pick_mask[i] = (i > int'(pick_idx));
      end
      pick_onehot = REQ_WIDTH'(1) << pick_idx;

      start = 1'b0;
      rearb = 1'b0;
      dec   = 1'b0;
      case (state)
         IDLE: start = |req;
         BUSY: begin
            if (withdrew) begin
               rearb = 1'b1;
            end else if (ack && !lock[gnt_idx]) begin
               if (credit > WEIGHT_W'(1)) dec = 1'b1;
               else                       rearb = 1'b1;
            end
         end
         default: ;
      endcase
      load = (start || rearb) && (|cand);
      drop = rearb && !(|cand);
   end

   // Grant, credit and priority-mask registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         gnt     <= '0;
         gnt_vld <= 1'b0;
         gnt_idx <= '0;
         credit  <= '0;
         mask    <= '1;
      end else if (load) begin
         state   <= BUSY;
         gnt     <= pick_onehot;
         gnt_vld <= 1'b1;
         gnt_idx <= pick_idx;
         credit  <= pick_credit;
         mask    <= pick_mask;
      end else if (drop) begin
         state   <= IDLE;
         gnt     <= '0;
         gnt_vld <= 1'b0;
         credit  <= '0;
      end else if (dec) begin
         credit  <= credit - WEIGHT_W'(1);
      end
   end

endmodule

// File: tb/tb_arbiter_wrr_lock.sv
// Bench for arbiter_wrr_lock: directed scenarios plus random traffic against a pointer-based model.
module tb_arbiter_wrr_lock;

   localparam int unsigned N  = 8;
   localparam int unsigned WW = 4;

   logic          clk;
   logic          rst_n;
   logic [N-1:0]  req;
   logic [N*WW-1:0] weight;
   logic [N-1:0]  lock;
   logic          ack;
   logic [N-1:0]  gnt;
   logic          gnt_vld;
   logic [2:0]    gnt_idx;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: current holder (-1 idle), remaining beats, last winner pointer
   int m_cur;
   int m_credit;
   int m_last;
   int m_idx;

   arbiter_wrr_lock #(.REQ_WIDTH(N), .WEIGHT_W(WW)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .weight(weight), .lock(lock),
      .ack(ack), .gnt(gnt), .gnt_vld(gnt_vld), .gnt_idx(gnt_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int w_of(input int j);
      logic [N*WW-1:0] w;
      w = weight;
      return int'(w[j*WW +: WW]);
   endfunction

   // First requester after the last winner, scanning circularly
   function automatic int pick(input logic [N-1:0] r);
      for (int k = 1; k <= N; k++) begin
         int j;
         j = (m_last + k) % N;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   task automatic m_grant(input logic [N-1:0] r);
      int p;
      p = pick(r);
      if (p < 0) begin
         m_cur = -1;
      end else begin
         m_cur    = p;
         m_last   = p;
         m_idx    = p;
         m_credit = (w_of(p) == 0) ? 1 : w_of(p);
      end
   endtask

   task automatic m_reset();
      m_cur = -1; m_credit = 0; m_last = N - 1; m_idx = 0;
   endtask

   task automatic m_step();
      logic [N-1:0] r;
      if (m_cur < 0) begin
         if (req != 0) m_grant(req);
      end else if (!req[m_cur]) begin
         r = req;
         r[m_cur] = 1'b0;
         m_grant(r);
      end else if (ack) begin
         if (lock[m_cur])       ;
         else if (m_credit > 1) m_credit--;
         else                   m_grant(req);
      end
   endtask

   function automatic logic [N-1:0] m_gnt();
      logic [N-1:0] g;
      g = '0;
      if (m_cur >= 0) g[m_cur] = 1'b1;
      return g;
   endfunction

   // Apply inputs for one cycle, advance model, compare after the edge
   task automatic step(input logic [N-1:0] r, input logic a, input logic [N-1:0] l);
      req = r; ack = a; lock = l;
      m_step();
      @(posedge clk);
      #1;
      check("gnt", 32'(gnt), 32'(m_gnt()));
      check("gnt_vld", 32'(gnt_vld), 32'(m_cur >= 0));
      check("gnt_idx", 32'(gnt_idx), 32'(m_idx));
      check("onehot0", 32'($onehot0(gnt)), 32'd1);
   endtask

   task automatic reset_dut();
      req = '0; ack = 1'b0; lock = '0;
      rst_n = 1'b0;
      m_reset();
      #1;
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_vld", 32'(gnt_vld), 32'd0);
      check("rst_idx", 32'(gnt_idx), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic set_weights_all(input int w);
      for (int j = 0; j < N; j++) weight[j*WW +: WW] = WW'(w);
   endtask

   initial begin
      rst_n = 1'b1; req = '0; ack = 1'b0; lock = '0;
      set_weights_all(1);
      m_reset();
      #3;

      // 1: reset state and single-cycle latency
      reset_dut();
      step(8'h00, 1'b0, 8'h00);
      check("t1_idle", 32'(gnt), 32'h0);
      step(8'h01, 1'b0, 8'h00);
      check("t1_gnt", 32'(gnt), 32'h01);
      check("t1_idx", 32'(gnt_idx), 32'd0);

      // 2: unit weights, full request, back-to-back rotation with wrap
      reset_dut();
      for (int k = 0; k < 9; k++) begin
         step(8'hFF, 1'b1, 8'h00);
         check("t2_order", 32'(gnt), 32'(1) << (k % 8));
      end

      // 3: weight 3 on requester 2
      reset_dut();
      weight[2*WW +: WW] = 4'd3;
      for (int k = 0; k < 8; k++) begin
         step(8'h0C, 1'b1, 8'h00);
         check("t3_seq", 32'(gnt), (k % 4 == 3) ? 32'h08 : 32'h04);
      end
      set_weights_all(1);

      // 4: lock holds for five acks, then one credit beat
      reset_dut();
      step(8'h03, 1'b0, 8'h01);
      check("t4_first", 32'(gnt), 32'h01);
      for (int k = 0; k < 5; k++) begin
         step(8'h03, 1'b1, 8'h01);
         check("t4_locked", 32'(gnt), 32'h01);
      end
      step(8'h03, 1'b1, 8'h00);
      check("t4_handover", 32'(gnt), 32'h02);

      // 5: holder withdraws without ack, next holder gets its own weight
      reset_dut();
      weight[4*WW +: WW] = 4'd2;
      step(8'h08, 1'b0, 8'h00);
      check("t5_hold3", 32'(gnt), 32'h08);
      step(8'h30, 1'b0, 8'h00);
      check("t5_withdraw", 32'(gnt), 32'h10);
      step(8'h30, 1'b1, 8'h00);
      check("t5_credit2", 32'(gnt), 32'h10);
      step(8'h30, 1'b1, 8'h00);
      check("t5_next", 32'(gnt), 32'h20);
      set_weights_all(1);

      // 6: async reset mid-grant, pick restarts from bit 0
      reset_dut();
      step(8'h40, 1'b0, 8'h00);
      check("t6_busy", 32'(gnt), 32'h40);
      #2;
      reset_dut();
      step(8'hC0, 1'b0, 8'h00);
      check("t6_restart", 32'(gnt), 32'h40);

      // Random traffic with weight changes, locks, withdrawals and a mid-run reset
      reset_dut();
      for (int c = 0; c < 1500; c++) begin
         logic [N-1:0] r;
         logic [N-1:0] l;
         if ($urandom_range(0, 49) == 0) begin
            for (int j = 0; j < N; j++) weight[j*WW +: WW] = WW'($urandom_range(0, 4));
         end
         r = N'($urandom) & N'($urandom | $urandom);
         if ($urandom_range(0, 9) == 0) r = '0;
         l = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         if (c == 800) begin
            #2;
            reset_dut();
         end
         step(r, 1'($urandom_range(0, 9) < 7), l);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
